// File: rtl/decoder_negedge_t_pkg.sv
// Shared definitions for the temporal-line thermometer encoder/decoder pair:
// window default, decoder FSM states and the thermometer construction function.
package decoder_negedge_t_pkg;

  localparam int WINDOW_DEFAULT = 8;
  localparam int THERM_MAX      = 64;
  localparam int COUNT_W        = $clog2(THERM_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Thermometer code with 'count' ones packed at the LSB end; callers truncate
  // to their own window width.
  function automatic logic [THERM_MAX-1:0] therm_from_count(input logic [COUNT_W-1:0] count);
    logic [THERM_MAX-1:0] ones;
    ones = '1;
    if (count >= COUNT_W'(THERM_MAX)) return ones;
    return ones >> (COUNT_W'(THERM_MAX) - count);
  endfunction

endpackage

// File: rtl/decoder_negedge_t.sv
// Temporal-line decoder: after an accepted start, the index of the first low
// line sample selects a thermometer value; an all-high window decodes to zero.
module decoder_negedge_t
  import decoder_negedge_t_pkg::*;
#(
  parameter int WINDOW = WINDOW_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              incoming_line,
  input  logic              start_valid,
  output logic              start_ready,
  output logic [WINDOW-1:0] value_out,
  output logic              value_valid,
  input  logic              value_ready,
  output logic              drop_error
);

  localparam int K_W = $clog2(WINDOW + 1);

  state_e            r_state;
  state_e            w_next_state;
  logic [K_W-1:0]    r_k;
  logic [K_W-1:0]    w_next_k;
  logic [WINDOW-1:0] r_value;
  logic [WINDOW-1:0] w_next_value;
  logic              r_drop;

  logic              w_start_ready;
  logic              w_accept;
  logic [COUNT_W-1:0] w_ones;
  logic [WINDOW-1:0] w_therm;

  assign w_start_ready = (r_state == IDLE) | ((r_state == DONE) & value_ready);
  assign w_accept      = start_valid & w_start_ready;

  // First low at index k yields all-ones >> k, i.e. WINDOW-k ones.
  assign w_ones  = COUNT_W'(WINDOW) - COUNT_W'(r_k);
  assign w_therm = WINDOW'(therm_from_count(w_ones));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_next_k     = r_k;
    w_next_value = r_value;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = SAMPLE;
          w_next_k     = '0;
        end
      end
      SAMPLE: begin
        if (!incoming_line) begin
          w_next_state = DONE;
          w_next_value = w_therm;
        end else if (r_k == K_W'(WINDOW - 1)) begin
          w_next_state = DONE;
          w_next_value = '0;
        end else begin
          w_next_k = r_k + 1'b1;
        end
      end
      DONE: begin
        if (value_ready) begin
          if (w_accept) begin
            w_next_state = SAMPLE;
            w_next_k     = '0;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_value <= '0;
      r_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // pre-edge values, independent of statement order.
      r_state <= w_next_state;
      r_k     <= w_next_k;
      r_value <= w_next_value;
      r_drop  <= r_drop | (start_valid & ~w_start_ready);
    end
  end

  assign start_ready = w_start_ready;
  assign value_out   = r_value;
  assign value_valid = (r_state == DONE);
  assign drop_error  = r_drop;

endmodule
